// File: rtl/gc_ram_arbiter.sv
// Request/grant arbiter for the shared 256-bit controller-state SRAM read port.
// Four ports each read single bits from their own 64-bit quarter; one-hot ack returns each bit.
module gc_ram_arbiter #(
  parameter int unsigned RAM_LATENCY = 1,
  parameter bit          WORK_CONS   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [23:0] req_addr,
  output logic [7:0]  ram_addr,
  input  logic        ram_data,
  output logic        data_out,
  output logic [3:0]  ack
);

  logic [3:0] pending_q, pending_d;
  logic [3:0] tag_q, tag_d;
  logic [3:0] ack_q, ack_d;
  logic [3:0] pipe_q [RAM_LATENCY];
  logic [3:0] pipe_d [RAM_LATENCY];
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] slot_q, slot_d;
  logic [7:0] ram_addr_q, ram_addr_d;
  logic       data_out_q, data_out_d;

  logic [3:0] eligible;
  logic [3:0] grant_oh;
  logic [1:0] grant_idx;
  logic [1:0] scan_idx;
  logic       grant_vld;
  logic [5:0] port_addr;

  // Arbitration: round-robin over eligible ports, or a fixed slot rotation.
  always_comb begin
    eligible  = req & ~pending_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (WORK_CONS) begin
      for (int unsigned i = 0; i < 4; i++) begin
        scan_idx = rr_ptr_q + i[1:0];
        if (!grant_vld && eligible[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end else begin
      grant_vld = eligible[slot_q];
      grant_idx = slot_q;
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    port_addr = req_addr[5:0];
      2'd1:    port_addr = req_addr[11:6];
      2'd2:    port_addr = req_addr[17:12];
      default: port_addr = req_addr[23:18];
    endcase
  end

  // tag_q sits alongside ram_addr; pipe_q[RAM_LATENCY-1] lines up with valid ram_data.
  always_comb begin
    grant_oh   = grant_vld ? (4'b0001 << grant_idx) : '0;
    tag_d      = grant_oh;
    ram_addr_d = grant_vld ? {grant_idx, port_addr} : ram_addr_q;
    rr_ptr_d   = (WORK_CONS && grant_vld) ? grant_idx + 2'd1 : rr_ptr_q;
    slot_d     = slot_q + 2'd1;
    pipe_d[0]  = tag_q;
    for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    ack_d      = pipe_q[RAM_LATENCY-1];
    data_out_d = (|ack_d) ? ram_data : data_out_q;
    pending_d  = (pending_q & ~ack_d) | grant_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      tag_q      <= '0;
      ack_q      <= '0;
      rr_ptr_q   <= '0;
      slot_q     <= '0;
      ram_addr_q <= '0;
      data_out_q <= 1'b0;
      for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      tag_q      <= tag_d;
      ack_q      <= ack_d;
      rr_ptr_q   <= rr_ptr_d;
      slot_q     <= slot_d;
      ram_addr_q <= ram_addr_d;
      data_out_q <= data_out_d;
      for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign ram_addr = ram_addr_q;
  assign data_out = data_out_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_gc_ram_arbiter.sv
// Bench for gc_ram_arbiter: three configurations share stimulus, each checked against
// a transaction-level model (grant rules, outstanding-read list keyed by due cycle).
module tb_gc_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [23:0] req_addr;
  bit          mem [256];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int due;
    int port;
    bit data;
  } rd_t;

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 1'($urandom);
  end

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 3);
    localparam bit          WC  = (g != 2);

    logic [7:0] ram_addr;
    logic       ram_data;
    logic       data_out;
    logic [3:0] ack;
    bit         rd_pipe [LAT];

    gc_ram_arbiter #(.RAM_LATENCY(LAT), .WORK_CONS(WC)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_addr (req_addr),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .data_out (data_out),
      .ack      (ack)
    );

    // Synchronous SRAM: data for the address present at an edge appears LAT edges later.
    always @(posedge clk) begin
      rd_pipe[0] <= mem[ram_addr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_data = rd_pipe[LAT-1];

    bit   [3:0] m_pend, m_ack, m_elig;
    int         m_rr, m_slot, m_cyc, m_gp;
    bit         m_valid = 1'b0;
    rd_t        m_q[$];
    logic [3:0] e_ack;
    logic       e_data;
    logic [7:0] e_addr;
    logic [5:0] m_a;

    initial begin
      m_pend = '0; m_rr = 0; m_slot = 0; m_cyc = 0;
      e_ack = '0; e_data = 1'b0; e_addr = '0;
      forever begin
        @(posedge clk);
        if (reset) begin
          m_pend = '0; m_rr = 0; m_slot = 0; m_q.delete();
          e_ack = '0; e_data = 1'b0; e_addr = '0;
          m_valid = 1'b1;
        end else begin
          m_ack = '0;
          for (int k = m_q.size() - 1; k >= 0; k--) begin
            if (m_q[k].due == m_cyc) begin
              m_ack[m_q[k].port] = 1'b1;
              e_data = m_q[k].data;
              m_q.delete(k);
            end
          end
          e_ack = m_ack;
          m_elig = req & ~m_pend;
          m_gp = -1;
          if (WC) begin
            for (int k = 0; k < 4; k++)
              if (m_gp < 0 && m_elig[(m_rr + k) % 4]) m_gp = (m_rr + k) % 4;
          end else if (m_elig[m_slot]) begin
            m_gp = m_slot;
          end
          m_pend = m_pend & ~m_ack;
          if (m_gp >= 0) begin
            m_a = req_addr[6*m_gp +: 6];
            e_addr = {m_gp[1:0], m_a};
            m_pend[m_gp] = 1'b1;
            m_q.push_back('{due: m_cyc + int'(LAT) + 1, port: m_gp, data: mem[e_addr]});
            if (WC) m_rr = (m_gp + 1) % 4;
          end
          m_slot = (m_slot + 1) % 4;
        end
        m_cyc++;
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        if (m_valid) begin
          chk_eq($sformatf("d%0d_ack", g), 32'(ack), 32'(e_ack));
          chk_eq($sformatf("d%0d_ram_addr", g), 32'(ram_addr), 32'(e_addr));
          chk_eq($sformatf("d%0d_data_out", g), 32'(data_out), 32'(e_data));
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [3:0] q, input int n);
    repeat (n) begin
      @(negedge clk);
      reset = r;
      req   = q;
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'h0;
    req_addr = 24'h0;
    // Reset with all requests high, then continuous four-port load.
    cyc(1'b1, 4'hF, 3);
    cyc(1'b0, 4'hF, 24);
    // Single port 2, bit 37 -> ram_addr 8'hA5.
    cyc(1'b1, 4'h0, 2);
    req_addr[17:12] = 6'd37;
    cyc(1'b0, 4'b0100, 10);
    // Leave rr_ptr at 1, then ports 3 and 0 compete.
    cyc(1'b1, 4'h0, 2);
    cyc(1'b0, 4'b0001, 1);
    cyc(1'b0, 4'b0000, 5);
    cyc(1'b0, 4'b1001, 12);
    // Reset on the clock after a port-1 grant.
    cyc(1'b1, 4'h0, 2);
    cyc(1'b0, 4'b0010, 1);
    cyc(1'b1, 4'b0010, 2);
    cyc(1'b0, 4'b0000, 8);
    // Port 3 drops then re-raises its request.
    cyc(1'b1, 4'h0, 2);
    cyc(1'b0, 4'b1000, 1);
    cyc(1'b0, 4'b0000, 2);
    cyc(1'b0, 4'b1000, 10);
    // Randomized traffic with occasional resets.
    repeat (3000) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      req   = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_addr = 24'($urandom);
    end
    cyc(1'b0, 4'h0, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
